// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - in-flight destination tracker driving stall and forwarding selects
module pipe_hazard_unit #(
    parameter int  STAGES   = 3,
    parameter int  AW       = 5,
    parameter int  ALU_RDY  = 2,
    parameter int  LOAD_RDY = 3,
    localparam int SW       = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [AW-1:0]     id_rs,
    input  logic [AW-1:0]     id_rt,
    input  logic [1:0]        id_rs_need,
    input  logic [1:0]        id_rt_need,
    input  logic              id_wr,
    input  logic [AW-1:0]     id_dst,
    input  logic              id_load,
    input  logic              flush_id,
    input  logic              hold,
    output logic              stall,
    output logic [SW-1:0]     id_fwd_rs,
    output logic [SW-1:0]     id_fwd_rt,
    output logic [SW-1:0]     ex_fwd_rs,
    output logic [SW-1:0]     ex_fwd_rt,
    output logic [STAGES-1:0] slot_valid
);

    localparam logic [1:0] NEED_EX = 2'b01;
    localparam logic [1:0] NEED_ID = 2'b10;

    // Tracker: bit/entry k describes the instruction k stages past ID
    logic [STAGES:1] v_q;
    logic [STAGES:1] wr_q;
    logic [STAGES:1] ld_q;
    logic [AW-1:0]   dst_q [1:STAGES];
    logic [SW-1:0]   ex_rs_q;
    logic [SW-1:0]   ex_rt_q;

    // Operand 0 is rs, operand 1 is rt
    logic [AW-1:0] src    [2];
    logic [1:0]    need   [2];
    logic [1:0]    haz;
    logic [SW-1:0] id_sel [2];
    logic [SW-1:0] ex_sel [2];
    int            match_slot [2];
    int            match_rdy  [2];
    logic          issue;

    assign src[0]  = id_rs;
    assign src[1]  = id_rt;
    assign need[0] = id_rs_need;
    assign need[1] = id_rt_need;

    // Per operand: find the youngest producer and decide hazard or forwarding source
    always_comb begin
        for (int o = 0; o < 2; o++) begin
            haz[o]        = 1'b0;
            id_sel[o]     = '0;
            ex_sel[o]     = '0;
            match_slot[o] = 0;
            match_rdy[o]  = 0;
            // Scan oldest to youngest so the youngest match overwrites older ones
            for (int k = STAGES; k >= 1; k--) begin
                if (v_q[k] && wr_q[k] && dst_q[k] == src[o] && src[o] != '0) begin
                    match_slot[o] = k;
                    match_rdy[o]  = ld_q[k] ? LOAD_RDY : ALU_RDY;
                end
            end
            if (match_slot[o] != 0) begin
                if (need[o] == NEED_ID) begin
                    if (match_slot[o] < match_rdy[o]) haz[o] = 1'b1;
                    else id_sel[o] = SW'(match_slot[o]);
                end else if (need[o] == NEED_EX) begin
                    // Producer will have moved one slot on when the consumer reaches EX;
                    // a producer leaving WB now is covered by the write-through register file
                    if (match_slot[o] + 1 < match_rdy[o]) haz[o] = 1'b1;
                    else if (match_slot[o] < STAGES) ex_sel[o] = SW'(match_slot[o] + 1);
                end
            end
        end
    end

    assign stall      = hold | (id_valid & ~flush_id & (|haz));
    assign issue      = id_valid & ~flush_id & ~stall;
    assign id_fwd_rs  = id_sel[0];
    assign id_fwd_rt  = id_sel[1];
    assign ex_fwd_rs  = ex_rs_q;
    assign ex_fwd_rt  = ex_rt_q;
    assign slot_valid = v_q;

    // Advance the tracker and capture EX selects for the instruction entering slot 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q     <= '0;
            wr_q    <= '0;
            ld_q    <= '0;
            ex_rs_q <= '0;
            ex_rt_q <= '0;
            for (int k = 1; k <= STAGES; k++) dst_q[k] <= '0;
        end else if (!hold) begin
            v_q      <= {v_q[STAGES-1:1], issue};
            wr_q     <= {wr_q[STAGES-1:1], issue & id_wr};
            ld_q     <= {ld_q[STAGES-1:1], issue & id_load};
            dst_q[1] <= id_dst;
            for (int k = 2; k <= STAGES; k++) dst_q[k] <= dst_q[k-1];
            ex_rs_q  <= issue ? ex_sel[0] : '0;
            ex_rt_q  <= issue ? ex_sel[1] : '0;
        end
    end

endmodule
